// File: rtl/aes_encipher_param_if.sv
// Handshake, key-schedule and S-box signals of aes_encipher_param.
// The slave modport is the core; the master modport is the surrounding system.
interface aes_encipher_param_if;
    logic         init;
    logic [127:0] plaintext;
    logic [3:0]   round_idx;
    logic [127:0] round_key;
    logic [31:0]  sboxw;
    logic [31:0]  new_sboxw;
    logic [127:0] ciphertext;
    logic         ready;
    logic         result_valid;

    modport master (
        output init, plaintext, round_key, new_sboxw,
        input  round_idx, sboxw, ciphertext, ready, result_valid
    );

    modport slave (
        input  init, plaintext, round_key, new_sboxw,
        output round_idx, sboxw, ciphertext, ready, result_valid
    );
endinterface

// File: rtl/aes_encipher_param.sv
// Iterative AES-128/AES-256 block encipher: one S-box word per cycle, then one
// ShiftRows/MixColumns/AddRoundKey cycle per round, round keys fetched by index.
module aes_encipher_param #(
    parameter int KEY_LEN = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    aes_encipher_param_if.slave  bus
);
    localparam int          NR     = (KEY_LEN == 256) ? 14 : 10;
    localparam logic [3:0]  NR_IDX = 4'(NR);

    if (KEY_LEN != 128 && KEY_LEN != 256) begin : g_key_len_check
        $error("aes_encipher_param: KEY_LEN must be 128 or 256");
    end

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        ROUND
    } fsm_t;

    fsm_t                fsm_q, fsm_d;
    // Word 0 is the most significant word, so st_q[w] matches state[127-32w -: 32].
    logic [0:3][31:0]    st_q, st_d;
    logic [3:0]          rnd_q, rnd_d;
    logic [1:0]          wcnt_q, wcnt_d;
    logic [127:0]        ct_q, ct_d;
    logic                ready_q, ready_d;
    logic                rv_q, rv_d;
    logic [31:0]         sboxw_c;
    logic [127:0]        shifted;
    logic [127:0]        round_out;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_word(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        {b0, b1, b2, b3} = w;
        return {xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3,
                b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3,
                b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3,
                xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        return {mix_word(s[127:96]), mix_word(s[95:64]),
                mix_word(s[63:32]), mix_word(s[31:0])};
    endfunction

    // Byte i sits at column i/4, row i%4; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [0:15][7:0] b;
        b = s;
        return {b[0],  b[5],  b[10], b[15],
                b[4],  b[9],  b[14], b[3],
                b[8],  b[13], b[2],  b[7],
                b[12], b[1],  b[6],  b[11]};
    endfunction

    assign shifted   = shift_rows(st_q);
    assign round_out = ((rnd_q == NR_IDX) ? shifted : mix_columns(shifted)) ^ bus.round_key;

    always_comb begin
        fsm_d   = fsm_q;
        st_d    = st_q;
        rnd_d   = rnd_q;
        wcnt_d  = wcnt_q;
        ct_d    = ct_q;
        ready_d = ready_q;
        rv_d    = 1'b0;
        sboxw_c = '0;
        case (fsm_q)
            IDLE: begin
                if (bus.init) begin
                    st_d    = bus.plaintext ^ bus.round_key;
                    rnd_d   = 4'd1;
                    wcnt_d  = '0;
                    ready_d = 1'b0;
                    fsm_d   = SUB;
                end
            end
            SUB: begin
                sboxw_c      = st_q[wcnt_q];
                st_d[wcnt_q] = bus.new_sboxw;
                wcnt_d       = wcnt_q + 2'd1;
                if (wcnt_q == 2'd3) begin
                    fsm_d = ROUND;
                end
            end
            ROUND: begin
                st_d = round_out;
                if (rnd_q == NR_IDX) begin
                    ct_d    = round_out;
                    rv_d    = 1'b1;
                    ready_d = 1'b1;
                    rnd_d   = '0;
                    fsm_d   = IDLE;
                end else begin
                    rnd_d  = rnd_q + 4'd1;
                    wcnt_d = '0;
                    fsm_d  = SUB;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q   <= IDLE;
            st_q    <= '0;
            rnd_q   <= '0;
            wcnt_q  <= '0;
            ct_q    <= '0;
            ready_q <= 1'b1;
            rv_q    <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            st_q    <= st_d;
            rnd_q   <= rnd_d;
            wcnt_q  <= wcnt_d;
            ct_q    <= ct_d;
            ready_q <= ready_d;
            rv_q    <= rv_d;
        end
    end

    assign bus.round_idx    = rnd_q;
    assign bus.sboxw        = sboxw_c;
    assign bus.ciphertext   = ct_q;
    assign bus.ready        = ready_q;
    assign bus.result_valid = rv_q;
endmodule

// File: tb/tb_aes_encipher_param.sv
// Bench for aes_encipher_param: AES-128 and AES-256 instances against FIPS-197
// vectors and a byte-array AES model built from GF(2^8) arithmetic.
module tb_aes_encipher_param;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    aes_encipher_param_if b128();
    aes_encipher_param_if b256();

    aes_encipher_param #(.KEY_LEN(128)) u_aes128 (.clk(clk), .reset(reset), .bus(b128));
    aes_encipher_param #(.KEY_LEN(256)) u_aes256 (.clk(clk), .reset(reset), .bus(b256));

    localparam logic [255:0] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CTZ   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic [7:0]   sbox_t  [256];
    logic [127:0] ks_tmp  [16];
    logic [127:0] ks128   [16];
    logic [127:0] ks256   [16];
    logic [127:0] ks_zero [16];
    logic [15:0]  seen_last;
    int checks = 0;
    int errors = 0;

    assign b128.round_key = ks128[b128.round_idx];
    assign b256.round_key = ks256[b256.round_idx];
    assign b128.new_sboxw = {sbox_t[b128.sboxw[31:24]], sbox_t[b128.sboxw[23:16]],
                             sbox_t[b128.sboxw[15:8]],  sbox_t[b128.sboxw[7:0]]};
    assign b256.new_sboxw = {sbox_t[b256.sboxw[31:24]], sbox_t[b256.sboxw[23:16]],
                             sbox_t[b256.sboxw[15:8]],  sbox_t[b256.sboxw[7:0]]};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from the definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = '0;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_t[x] = s;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nr;
        rc = 8'h01;
        nr = nk + 6;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                w[i] = key[255 - 32 * i -: 32];
            end else begin
                t = w[i - 1];
                if (i % nk == 0) begin
                    t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = gmul(rc, 8'h02);
                end else if (nk > 6 && i % nk == 4) begin
                    t = sub_word(t);
                end
                w[i] = w[i - nk] ^ t;
            end
        end
        for (int r = 0; r < 16; r++) begin
            ks_tmp[r] = '0;
            if (r <= nr) ks_tmp[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] out;
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ ks_tmp[0][127 - 8 * i -: 8];
        for (int rr = 1; rr <= nr; rr++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4 * c + r] = s[4 * ((c + r) % 4) + r];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    if (rr < nr)
                        s[4 * c + r] = gmul(8'h02, t[4 * c + r]) ^ gmul(8'h03, t[4 * c + (r + 1) % 4])
                                     ^ t[4 * c + (r + 2) % 4] ^ t[4 * c + (r + 3) % 4];
                    else
                        s[4 * c + r] = t[4 * c + r];
            for (int i = 0; i < 16; i++) s[i] ^= ks_tmp[rr][127 - 8 * i -: 8];
        end
        for (int i = 0; i < 16; i++) out[127 - 8 * i -: 8] = s[i];
        return out;
    endfunction

    task automatic drive(input bit w256, input logic i, input logic [127:0] p);
        if (w256) begin
            b256.init = i;
            b256.plaintext = p;
        end else begin
            b128.init = i;
            b128.plaintext = p;
        end
    endtask

    // Counts negedges after the accepting edge until result_valid, bounded.
    task automatic wait_rv(input bit w256, input int poke_at, input logic [127:0] pt,
                           output int k, output int early_ready);
        k = 0;
        early_ready = 0;
        seen_last = '0;
        seen_last[w256 ? b256.round_idx : b128.round_idx] = 1'b1;
        while (k < 200) begin
            @(negedge clk);
            k++;
            if (k == poke_at) drive(w256, 1'b1, ~pt);
            if (k == poke_at + 1) drive(w256, 1'b0, pt);
            seen_last[w256 ? b256.round_idx : b128.round_idx] = 1'b1;
            if (w256 ? b256.result_valid : b128.result_valid) break;
            if (w256 ? b256.ready : b128.ready) early_ready++;
        end
    endtask

    task automatic run(input bit w256, input logic [127:0] pt, input logic [127:0] exp,
                       input string tag, input int poke_at);
        int k, early, lat_exp;
        lat_exp = w256 ? 70 : 50;
        @(negedge clk);
        drive(w256, 1'b1, pt);
        @(negedge clk);
        drive(w256, 1'b0, pt);
        chk({tag, " busy"}, 128'(w256 ? b256.ready : b128.ready), 128'(1'b0));
        wait_rv(w256, poke_at, pt, k, early);
        chk({tag, " latency"}, 128'(k), 128'(lat_exp));
        chk({tag, " ct"}, w256 ? b256.ciphertext : b128.ciphertext, exp);
        chk({tag, " ready at done"}, 128'(w256 ? b256.ready : b128.ready), 128'(1'b1));
        chk({tag, " early ready"}, 128'(early), 128'(0));
        @(negedge clk);
        chk({tag, " rv one cycle"}, 128'(w256 ? b256.result_valid : b128.result_valid), 128'(1'b0));
        chk({tag, " ct held"}, w256 ? b256.ciphertext : b128.ciphertext, exp);
    endtask

    initial begin
        logic [255:0] key;
        logic [127:0] pt, exp;
        int k, early, rv_count;

        drive(1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, '0);
        for (int i = 0; i < 16; i++) begin
            ks128[i] = '0;
            ks256[i] = '0;
        end
        build_sbox();

        // Reset values while reset is held low.
        @(negedge clk);
        chk("rst ready128", 128'(b128.ready), 128'(1'b1));
        chk("rst rv128", 128'(b128.result_valid), 128'(1'b0));
        chk("rst ct128", b128.ciphertext, '0);
        chk("rst idx128", 128'(b128.round_idx), '0);
        chk("rst sboxw128", 128'(b128.sboxw), '0);
        chk("rst ready256", 128'(b256.ready), 128'(1'b1));
        chk("rst ct256", b256.ciphertext, '0);
        reset = 1'b1;

        // Model sanity against the published vectors.
        expand('0, 4);
        chk("model zero", aes_ref('0, 10), CTZ);
        ks_zero = ks_tmp;
        expand(K256, 8);
        chk("model c3", aes_ref(PT, 14), CT256);
        ks256 = ks_tmp;
        expand(K128, 4);
        chk("model c1", aes_ref(PT, 10), CT128);
        ks128 = ks_tmp;

        run(1'b0, PT, CT128, "c1", -1);
        chk("c1 idx sweep", 128'(seen_last), 128'(16'h07ff));
        run(1'b1, PT, CT256, "c3", -1);
        chk("c3 idx sweep", 128'(seen_last), 128'(16'h7fff));

        for (int n = 0; n < 3; n++) begin
            key = {$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()};
            pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            expand(key, 4);
            ks128 = ks_tmp;
            exp = aes_ref(pt, 10);
            run(1'b0, pt, exp, $sformatf("rand128_%0d", n), -1);
            expand(key, 8);
            ks256 = ks_tmp;
            exp = aes_ref(pt, 14);
            run(1'b1, pt, exp, $sformatf("rand256_%0d", n), -1);
        end

        // Back-to-back: init held high, second block accepted on the result_valid cycle.
        expand(K128, 4);
        ks128 = ks_tmp;
        @(negedge clk);
        drive(1'b0, 1'b1, PT);
        @(negedge clk);
        wait_rv(1'b0, -1, PT, k, early);
        chk("b2b first latency", 128'(k), 128'(50));
        chk("b2b first ct", b128.ciphertext, CT128);
        ks128 = ks_zero;
        drive(1'b0, 1'b1, '0);
        @(negedge clk);
        chk("b2b second accepted ready", 128'(b128.ready), 128'(1'b0));
        chk("b2b second accepted idx", 128'(b128.round_idx), 128'(4'd1));
        drive(1'b0, 1'b0, '0);
        wait_rv(1'b0, -1, '0, k, early);
        chk("b2b second latency", 128'(k), 128'(50));
        chk("b2b second ct", b128.ciphertext, CTZ);
        chk("b2b early ready", 128'(early), 128'(0));

        // init while busy is ignored.
        ks128 = ks_tmp;
        run(1'b0, PT, CT128, "busy poke", 20);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        drive(1'b0, 1'b1, PT);
        @(negedge clk);
        drive(1'b0, 1'b0, PT);
        repeat (23) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort ready", 128'(b128.ready), 128'(1'b1));
        chk("abort ct", b128.ciphertext, '0);
        chk("abort idx", 128'(b128.round_idx), '0);
        chk("abort rv", 128'(b128.result_valid), 128'(1'b0));
        chk("abort sboxw", 128'(b128.sboxw), '0);
        rv_count = 0;
        repeat (3) begin
            @(negedge clk);
            rv_count += int'(b128.result_valid);
        end
        reset = 1'b1;
        repeat (60) begin
            @(negedge clk);
            rv_count += int'(b128.result_valid);
        end
        chk("abort no rv", 128'(rv_count), 128'(0));
        chk("abort ct stays 0", b128.ciphertext, '0);
        run(1'b0, PT, CT128, "c1 after reset", -1);

        // Idle hold with plaintext toggling.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            b128.plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
            chk("hold ct", b128.ciphertext, CT128);
            chk("hold rv", 128'(b128.result_valid), 128'(1'b0));
            chk("hold sboxw", 128'(b128.sboxw), '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
